// File: rtl/viking_pkg.sv
// Shared constants for the Viking/SM194 mono display path: frame geometry,
// frame base addresses and video bus slot encoding.
package viking_pkg;

  localparam logic [22:0] VIKING_BASE    = 23'h600000;
  localparam logic [22:0] VIKING_BASE_HI = 23'h740000;

  localparam int unsigned H              = 1280;
  localparam int unsigned V              = 1024;
  localparam int unsigned WORDS_PER_LINE = H / 64;

  typedef enum logic [1:0] {
    BUS_SLOT0 = 2'd0,
    BUS_SLOT1 = 2'd1,
    BUS_VIDEO = 2'd2,
    BUS_SLOT3 = 2'd3
  } bus_slot_e;

  // RAM delivers the four 16-bit pixel groups in reverse shift order.
  function automatic logic [63:0] swap_halfwords(input logic [63:0] w);
    return {w[15:0], w[31:16], w[47:32], w[63:48]};
  endfunction

endpackage

// File: rtl/viking_fifo.sv
// First-word-fall-through synchronous FIFO; rdata_o is zero while empty.
module viking_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/viking_fetch.sv
// Video prefetch: issues reads in the video bus slot, reorders each word and
// buffers it for the pixel serializer.
module viking_fetch
  import viking_pkg::*;
#(
  parameter logic [22:0] BASE           = VIKING_BASE,
  parameter logic [22:0] BASE_HI        = VIKING_BASE_HI,
  parameter int unsigned WORDS_PER_LINE = viking_pkg::WORDS_PER_LINE,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                       pclk,
  input  logic                       reset_n,
  input  logic                       himem,
  input  logic                       clk_8_en,
  input  logic [1:0]                 bus_cycle,
  input  logic                       frame_start,
  input  logic                       line_start,
  output logic [22:0]                addr,
  output logic                       read,
  input  logic [63:0]                data,
  input  logic                       pop,
  output logic [63:0]                pix_word,
  output logic                       word_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underflow
);

  localparam int unsigned RW = ($clog2(WORDS_PER_LINE + 1) > 5) ?
                               $clog2(WORDS_PER_LINE + 1) : 5;

  logic [22:0]   addr_q, addr_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          underflow_q, underflow_d;
  logic          fifo_full, fifo_empty, push;

  assign read       = (bus_slot_e'(bus_cycle) == BUS_VIDEO) && (rem_q != '0) && !fifo_full;
  assign push       = clk_8_en && read && !frame_start;
  assign addr       = addr_q;
  assign underflow  = underflow_q;
  assign word_valid = !fifo_empty;

  // frame_start overrides push/pop; line_start is applied last so it wins on rem.
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    underflow_d = underflow_q;
    if (frame_start) begin
      addr_d      = himem ? BASE_HI : BASE;
      rem_d       = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        addr_d = addr_q + 23'd4;
        rem_d  = rem_q - RW'(1);
      end
      if (pop && fifo_empty) underflow_d = 1'b1;
    end
    if (line_start) rem_d = RW'(WORDS_PER_LINE);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= BASE;
      rem_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      underflow_q <= underflow_d;
    end
  end

  viking_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst_n   (reset_n),
    .flush_i (frame_start),
    .push_i  (push),
    .wdata_i (swap_halfwords(data)),
    .pop_i   (pop && !frame_start),
    .rdata_o (pix_word),
    .level_o (level),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_viking_fetch.sv
// Directed bench for viking_fetch: fetch/addressing, reorder, FIFO full/empty,
// underflow and frame_start priority.
module tb_viking_fetch;

  logic        pclk;
  logic        reset_n;
  logic        himem;
  logic        clk_8_en;
  logic [1:0]  bus_cycle;
  logic        frame_start;
  logic        line_start;
  logic [22:0] addr;
  logic        read;
  logic [63:0] data;
  logic        pop;
  logic [63:0] pix_word;
  logic        word_valid;
  logic [2:0]  level;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  bit auto_pop = 0;

  viking_fetch #(
    .BASE           (23'h600000),
    .BASE_HI        (23'h740000),
    .WORDS_PER_LINE (20),
    .DEPTH          (4)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .himem       (himem),
    .clk_8_en    (clk_8_en),
    .bus_cycle   (bus_cycle),
    .frame_start (frame_start),
    .line_start  (line_start),
    .addr        (addr),
    .read        (read),
    .data        (data),
    .pop         (pop),
    .pix_word    (pix_word),
    .word_valid  (word_valid),
    .level       (level),
    .underflow   (underflow)
  );

  initial begin
    pclk = 1'b0;
    forever #4 pclk = ~pclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (auto_pop) pop = word_valid;
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_slot(input logic [1:0] bc);
    bus_cycle = bc;
    clk_8_en  = 1'b0;
    tick();
    clk_8_en  = 1'b1;
    tick();
    clk_8_en  = 1'b0;
  endtask

  // RAM word r: halfwords A,B,C,D from MSB down; expected serializer order D,C,B,A.
  function automatic logic [63:0] mk(input int r);
    logic [15:0] k;
    k = 16'(r);
    return {16'hA000 | k, 16'hB000 | k, 16'hC000 | k, 16'hD000 | k};
  endfunction

  function automatic logic [63:0] ex(input int r);
    logic [15:0] k;
    k = 16'(r);
    return {16'hD000 | k, 16'hC000 | k, 16'hB000 | k, 16'hA000 | k};
  endfunction

  initial begin
    reset_n = 1'b0; himem = 1'b0; clk_8_en = 1'b0; bus_cycle = 2'd2;
    frame_start = 1'b0; line_start = 1'b0; data = '0; pop = 1'b0;
    #10;
    check("rst_addr", 64'(addr), 64'h600000);
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_pix", pix_word, 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_read", 64'(read), 64'd0);
    #8 reset_n = 1'b1;
    tick();

    // Fill without popping: four pushes, then full.
    bus_cycle = 2'd0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    line_start  = 1'b1; tick(); line_start  = 1'b0;
    check("fill_addr0", 64'(addr), 64'h600000);
    for (int r = 0; r < 5; r++) begin
      bus_slot(2'd0);
      bus_slot(2'd1);
      data = (r == 0) ? 64'h1111_2222_3333_4444 : mk(r);
      if (r == 4) begin
        bus_cycle = 2'd2;
        #1 check("full_read_low", 64'(read), 64'd0);
      end
      bus_slot(2'd2);
      if (r == 0) begin
        check("reorder_pix", pix_word, 64'h4444_3333_2222_1111);
        check("reorder_valid", 64'(word_valid), 64'd1);
      end
      check("fill_addr", 64'(addr), 64'h600004 + 64'(4 * ((r < 4) ? r : 3)));
      bus_slot(2'd3);
    end
    check("full_level", 64'(level), 64'd4);

    // Pop at full in the video slot: read was low, so no push this slot.
    bus_cycle = 2'd2; clk_8_en = 1'b0; data = mk(4);
    tick();
    clk_8_en = 1'b1; pop = 1'b1;
    #1 check("full_pop_read", 64'(read), 64'd0);
    tick();
    clk_8_en = 1'b0; pop = 1'b0;
    check("full_pop_level", 64'(level), 64'd3);
    check("full_pop_addr", 64'(addr), 64'h600010);
    check("full_pop_head", pix_word, ex(1));
    bus_slot(2'd3);
    bus_slot(2'd0);
    bus_slot(2'd1);
    bus_slot(2'd2);
    check("refill_level", 64'(level), 64'd4);
    check("refill_addr", 64'(addr), 64'h600014);

    // frame_start with himem=1 coincident with a push at level 2.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    line_start  = 1'b1; tick(); line_start  = 1'b0;
    data = mk(10); bus_slot(2'd2);
    data = mk(11); bus_slot(2'd2);
    check("pre_fs_level", 64'(level), 64'd2);
    check("pre_fs_addr", 64'(addr), 64'h600008);
    bus_cycle = 2'd2; clk_8_en = 1'b0; data = mk(12);
    tick();
    clk_8_en = 1'b1; frame_start = 1'b1; himem = 1'b1;
    #1 check("fs_read_high", 64'(read), 64'd1);
    tick();
    clk_8_en = 1'b0; frame_start = 1'b0; himem = 1'b0;
    check("fs_level", 64'(level), 64'd0);
    check("fs_addr_hi", 64'(addr), 64'h740000);
    check("fs_valid", 64'(word_valid), 64'd0);
    check("fs_pix", pix_word, 64'd0);
    tick();
    check("himem_held", 64'(addr), 64'h740000);
    check("fs_rem_zero_read", 64'(read), 64'd0);

    // Pop while empty, then frame_start clears the sticky flag.
    pop = 1'b1; tick(); pop = 1'b0;
    check("uf_set", 64'(underflow), 64'd1);
    check("uf_level", 64'(level), 64'd0);
    tick();
    check("uf_sticky", 64'(underflow), 64'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("uf_clear", 64'(underflow), 64'd0);
    check("fs_addr_lo", 64'(addr), 64'h600000);

    // Full line with the serializer popping whenever a word is available.
    line_start = 1'b1; tick(); line_start = 1'b0;
    auto_pop = 1'b1;
    for (int r = 0; r < 22; r++) begin
      bus_slot(2'd0);
      bus_slot(2'd1);
      data = mk(20 + r);
      bus_slot(2'd2);
      if (r < 20) check("line_pix", pix_word, ex(20 + r));
      bus_slot(2'd3);
    end
    auto_pop = 1'b0; pop = 1'b0;
    bus_cycle = 2'd2;
    #1;
    check("line_addr_end", 64'(addr), 64'h600050);
    check("line_read_low", 64'(read), 64'd0);
    check("line_underflow", 64'(underflow), 64'd0);
    check("line_level", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
